// File: rtl/ac_e_unit.sv
// Accumulator, E flip-flop and status flags behind the ALU.
// Latches ALU results, runs CLA/CLE/CME/INC and skip tests.
module ac_e_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_en,
  input  logic [3:0]   cmd,
  input  logic [W-1:0] alu_result,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic [W-1:0] ac,
  output logic         e,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         skip
);

  localparam logic [3:0] C_NOP = 4'd0;
  localparam logic [3:0] C_LD  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_CIR = 4'd3;
  localparam logic [3:0] C_CIL = 4'd4;
  localparam logic [3:0] C_CLA = 4'd5;
  localparam logic [3:0] C_CLE = 4'd6;
  localparam logic [3:0] C_CME = 4'd7;
  localparam logic [3:0] C_INC = 4'd8;
  localparam logic [3:0] C_SPA = 4'd9;
  localparam logic [3:0] C_SNA = 4'd10;
  localparam logic [3:0] C_SZA = 4'd11;
  localparam logic [3:0] C_SZE = 4'd12;

  // Incrementer with carry-out; bit W marks the all-ones wrap.
  logic [W:0] inc_sum;
  assign inc_sum = {1'b0, ac} + {{W{1'b0}}, 1'b1};

  // Register update for all commands; skip pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac     <= '0;
      e      <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      skip   <= 1'b0;
    end else begin
      skip <= 1'b0;
      if (cmd_en) begin
        case (cmd)
          C_LD: begin
            ac     <= alu_result;
            flag_n <= alu_n;
            flag_z <= alu_z;
          end
          C_ADD: begin
            ac     <= alu_result;
            e      <= alu_co;
            flag_c <= alu_co;
            flag_v <= alu_ovf;
            flag_n <= alu_n;
            flag_z <= alu_z;
          end
          C_CIR: begin
            ac     <= alu_result;
            e      <= ac[0];
            flag_c <= ac[0];
            flag_n <= alu_n;
            flag_z <= alu_z;
          end
          C_CIL: begin
            ac     <= alu_result;
            e      <= ac[W-1];
            flag_c <= ac[W-1];
            flag_n <= alu_n;
            flag_z <= alu_z;
          end
          C_CLA: begin
            ac     <= '0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
          end
          C_CLE: e <= 1'b0;
          C_CME: e <= ~e;
          C_INC: begin
            ac     <= inc_sum[W-1:0];
            flag_c <= inc_sum[W];
            flag_n <= inc_sum[W-1];
            flag_z <= (inc_sum[W-1:0] == '0);
          end
          C_SPA: skip <= ~ac[W-1];
          C_SNA: skip <= ac[W-1];
          C_SZA: skip <= (ac == '0);
          C_SZE: skip <= ~e;
          C_NOP: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac_e_unit.sv
// Directed bench for ac_e_unit with a scoreboard of
// expected register states checked after each edge.
module tb_ac_e_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_en;
  logic [3:0]   cmd;
  logic [W-1:0] alu_result;
  logic         alu_co, alu_ovf, alu_n, alu_z;
  logic [W-1:0] ac;
  logic         e, flag_n, flag_z, flag_c, flag_v, skip;

  typedef struct {
    logic [W-1:0] ac;
    logic e, n, z, c, v, skip;
  } st_t;

  st_t m;
  st_t q[$];
  int checks = 0;
  int errors = 0;

  ac_e_unit #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_en(cmd_en), .cmd(cmd),
    .alu_result(alu_result),
    .alu_co(alu_co), .alu_ovf(alu_ovf),
    .alu_n(alu_n), .alu_z(alu_z),
    .ac(ac), .e(e),
    .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v),
    .skip(skip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input st_t x);
    chk({tag, ".ac"}, 32'(ac), 32'(x.ac));
    chk({tag, ".e"}, 32'(e), 32'(x.e));
    chk({tag, ".n"}, 32'(flag_n), 32'(x.n));
    chk({tag, ".z"}, 32'(flag_z), 32'(x.z));
    chk({tag, ".c"}, 32'(flag_c), 32'(x.c));
    chk({tag, ".v"}, 32'(flag_v), 32'(x.v));
    chk({tag, ".skip"}, 32'(skip), 32'(x.skip));
  endtask

  function automatic st_t zero_st();
    st_t x;
    x.ac = '0; x.e = 0; x.n = 0;
    x.z = 0; x.c = 0; x.v = 0; x.skip = 0;
    return x;
  endfunction

  // Drive one cycle, predict, push, then pop and compare.
  task automatic step(input string tag,
                      input logic en,
                      input logic [3:0] c,
                      input logic [W-1:0] r,
                      input logic co, ovf, n, z);
    st_t x;
    st_t got;
    logic [W:0] s;
    @(negedge clk);
    cmd_en = en; cmd = c; alu_result = r;
    alu_co = co; alu_ovf = ovf; alu_n = n; alu_z = z;
    x = m;
    x.skip = 1'b0;
    if (en) begin
      case (c)
        4'd1: begin x.ac = r; x.n = n; x.z = z; end
        4'd2: begin
          x.ac = r; x.e = co; x.c = co;
          x.v = ovf; x.n = n; x.z = z;
        end
        4'd3: begin
          x.ac = r; x.e = m.ac[0]; x.c = m.ac[0];
          x.n = n; x.z = z;
        end
        4'd4: begin
          x.ac = r; x.e = m.ac[W-1]; x.c = m.ac[W-1];
          x.n = n; x.z = z;
        end
        4'd5: begin x.ac = '0; x.z = 1; x.n = 0; end
        4'd6: x.e = 1'b0;
        4'd7: x.e = ~m.e;
        4'd8: begin
          s = {1'b0, m.ac} + 1;
          x.ac = s[W-1:0];
          x.c = s[W];
          x.n = s[W-1];
          x.z = (s[W-1:0] == 0);
        end
        4'd9:  x.skip = (m.ac[W-1] == 1'b0);
        4'd10: x.skip = (m.ac[W-1] == 1'b1);
        4'd11: x.skip = (m.ac == 0);
        4'd12: x.skip = (m.e == 1'b0);
        default: ;
      endcase
    end
    m = x;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 32'(0), 32'(1));
    end else begin
      got = q.pop_front();
      chk_all(tag, got);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_en = 0; cmd = 0; alu_result = '0;
    alu_co = 0; alu_ovf = 0; alu_n = 0; alu_z = 0;
    m = zero_st();
    #12;
    chk_all("reset", m);
    @(negedge clk);
    rst = 1'b0;

    step("ld1234", 1, 4'd2, 16'h1234, 1, 1, 0, 0);
    step("cme", 1, 4'd7, 16'hAAAA, 0, 0, 1, 1);
    step("cme2", 1, 4'd7, 16'h0, 0, 0, 0, 0);

    // Mid-cycle reset with an ADD pending.
    @(negedge clk);
    #2;
    cmd_en = 1; cmd = 4'd2; alu_result = 16'hFFFF;
    alu_co = 1; alu_ovf = 1; alu_n = 1; alu_z = 0;
    rst = 1'b1;
    m = zero_st();
    #1;
    chk_all("rst_async", m);
    @(posedge clk);
    #1;
    chk_all("rst_hold", m);
    @(negedge clk);
    rst = 1'b0;
    cmd_en = 0;

    step("add0", 1, 4'd2, 16'h0000, 1, 0, 0, 1);
    step("ld8001", 1, 4'd1, 16'h8001, 0, 0, 1, 0);
    step("cle", 1, 4'd6, 16'h5555, 1, 1, 1, 1);
    step("cir", 1, 4'd3, 16'h4000, 0, 0, 0, 0);
    step("cil", 1, 4'd4, 16'h8001, 0, 0, 1, 0);
    step("ldffff", 1, 4'd1, 16'hFFFF, 0, 0, 1, 0);
    step("inc_wrap", 1, 4'd8, 16'h1111, 0, 1, 1, 0);
    step("sza1", 1, 4'd11, 16'h0, 0, 0, 0, 0);
    step("idle", 0, 4'd11, 16'h0, 0, 0, 0, 0);
    step("ld7fff", 1, 4'd1, 16'h7FFF, 0, 0, 0, 0);
    step("cme_e1", 1, 4'd7, 16'h0, 0, 0, 0, 0);
    step("spa", 1, 4'd9, 16'h0, 0, 0, 0, 0);
    step("sna", 1, 4'd10, 16'h0, 0, 0, 0, 0);
    step("sza0", 1, 4'd11, 16'h0, 0, 0, 0, 0);
    step("cme_e0", 1, 4'd7, 16'h0, 0, 0, 0, 0);
    step("sze", 1, 4'd12, 16'h0, 0, 0, 0, 0);
    step("cle2", 1, 4'd6, 16'h0, 0, 0, 0, 0);
    step("cme3", 1, 4'd7, 16'h0, 0, 0, 0, 0);
    step("sze0", 1, 4'd12, 16'h0, 0, 0, 0, 0);
    step("inc_n", 1, 4'd8, 16'h0, 1, 1, 0, 1);
    step("sna1", 1, 4'd10, 16'h0, 0, 0, 0, 0);
    step("add_v", 1, 4'd2, 16'h8000, 0, 1, 1, 0);
    step("en0_a", 0, 4'd2, 16'hDEAD, 1, 0, 0, 1);
    step("en0_b", 0, 4'd2, 16'hBEEF, 0, 1, 1, 1);
    step("en0_c", 0, 4'd2, 16'h0F0F, 1, 1, 0, 0);
    step("cmd14", 1, 4'd14, 16'h1234, 1, 0, 1, 1);
    step("cla", 1, 4'd5, 16'h9999, 1, 1, 1, 0);
    step("sza_cla", 1, 4'd11, 16'h0, 0, 0, 0, 0);
    step("nop", 1, 4'd0, 16'h7777, 1, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ac_e_unit.md
Name: ac_e_unit

Overview:
- Holds the accumulator AC, the E flip-flop and the registered status flags downstream of the ALU.
- Latches the ALU result and status outputs under command from the control sequencer.
- Executes the register-reference microoperations that do not need the ALU: CLA, CLE, CME, INC.
- Evaluates the skip tests SPA/SNA/SZA/SZE into a registered one-cycle skip pulse.
- Its AC and E outputs feed back into the ALU AC and E inputs.

Parameters:
- W, 16, data width of AC and of the ALU result.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_en  in  1  command strobe; cmd is acted on only when this is 1.
- cmd  in  4  command code; see Behaviour.
- alu_result  in  W  ALU Result.
- alu_co  in  1  ALU carry-out.
- alu_ovf  in  1  ALU overflow.
- alu_n  in  1  ALU negative.
- alu_z  in  1  ALU zero.
- ac  out  W  accumulator register; drives the ALU AC input.
- e  out  1  E flip-flop; drives the ALU E input.
- flag_n  out  1  registered negative flag.
- flag_z  out  1  registered zero flag.
- flag_c  out  1  registered carry flag.
- flag_v  out  1  registered overflow flag.
- skip  out  1  registered one-cycle skip request to the sequencer.

Behaviour:
- Reset: clk and rst are a single clock with asynchronous active-high reset.
  - rst=1 forces ac=0, e=0, flag_n=0, flag_z=0, flag_c=0, flag_v=0, skip=0 immediately, without waiting for clk.
  - A command in flight when rst asserts is discarded. The first command after release is accepted on the first rising edge with rst=0.
- All outputs are registered. Every command has 1-cycle latency: its effect is visible after the edge that samples cmd_en=1.
- cmd_en=0: ac, e and all flags hold; skip<=0.
- Commands (cmd_en=1):
  - 0 NOP: nothing changes; skip<=0.
  - 1 LD: ac<=alu_result; flag_n<=alu_n; flag_z<=alu_z; e, flag_c, flag_v hold. Used for AND, transfer DR and CMA.
  - 2 ADD: ac<=alu_result; e<=alu_co; flag_c<=alu_co; flag_v<=alu_ovf; flag_n<=alu_n; flag_z<=alu_z.
  - 3 CIR: ac<=alu_result; e<=old ac[0]; flag_c<=old ac[0]; flag_n<=alu_n; flag_z<=alu_z; flag_v holds.
  - 4 CIL: ac<=alu_result; e<=old ac[W-1]; flag_c<=old ac[W-1]; flag_n<=alu_n; flag_z<=alu_z; flag_v holds.
  - 5 CLA: ac<=0; flag_z<=1; flag_n<=0; e, flag_c, flag_v hold.
  - 6 CLE: e<=0; nothing else changes.
  - 7 CME: e<=~e; nothing else changes.
  - 8 INC: ac<=ac+1, computed internally modulo 2^W (all-ones wraps to 0).
    - flag_c<=1 only on wrap, else 0.
    - flag_n and flag_z are computed from the new value.
    - e and flag_v hold.
  - 9 SPA: skip<=(ac[W-1]==0).
  - 10 SNA: skip<=(ac[W-1]==1).
  - 11 SZA: skip<=(ac==0).
  - 12 SZE: skip<=(e==0).
  - Skip commands 9–12 test the registered ac/e at the sampling edge and change no other state.
  - 13–15: treated as NOP.
- skip is 1 for exactly the cycle after a qualifying skip command. It is 0 after every other command and on every idle cycle.
- Back-to-back commands are legal every cycle. Each command sees the state left by the previous one; for example, INC followed by SZA tests the incremented value.
- CIR/CIL require the ALU OP to be the matching shift in the same cycle. The unit does not check alu_* consistency; it latches whatever is presented.
- The ALU status inputs are ignored for commands 0 and 5–15.

Test Plan:
- rst pulse mid-cycle with ac=16'h1234, e=1 -> all outputs 0 before the next clk edge. An ADD applied while rst=1 has no effect.
- ADD with alu_result=16'h0000, alu_co=1, alu_ovf=0, alu_z=1 -> next cycle ac=16'h0000, e=1, flag_c=1, flag_z=1, flag_n=0.
- ac=16'h8001, e=0: CIR with alu_result=16'h4000 -> ac=16'h4000, e=1, flag_c=1. Then CIL with alu_result=16'h8001 -> e=0.
- ac=16'hFFFF, INC -> ac=16'h0000, flag_c=1, flag_z=1, e unchanged. Next-cycle SZA -> skip=1 for one cycle only, then 0.
- ac=16'h7FFF, e=1: SPA -> skip=1; SNA -> skip=0; CME then SZE -> skip=1; CLE then CME -> e=1.
- cmd_en=0 with cmd=2 and garbage alu_* for 3 cycles -> ac, e and flags unchanged, skip=0. cmd=14 with cmd_en=1 -> no change.
